// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The EX stage drives the master side; the sequencer implements the slave side.
interface muldiv_hilo_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             mf_req;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, op, src_a, src_b, mf_req,
      input  busy, stall, done, div_zero, hi_out, lo_out
   );

   modport slave (
      input  start, op, src_a, src_b, mf_req,
      output busy, stall, done, div_zero, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULTU/DIVU sequencer owning HI/LO: one bit per cycle through a shared
// double-width working register, committing to HI/LO only when the operation ends.
module muldiv_hilo_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   muldiv_hilo_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_COMMIT
   } state_t;

   localparam logic [1:0]       OP_MULTU = 2'b01;
   localparam logic [1:0]       OP_DIVU  = 2'b10;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t               state_q,    state_d;
   logic [CNT_W-1:0]     count_q,    count_d;
   logic [WIDTH-1:0]     a_q,        a_d;
   logic [WIDTH-1:0]     b_q,        b_d;
   logic [2*WIDTH-1:0]   acc_q,      acc_d;
   logic                 is_div_q,   is_div_d;
   logic [WIDTH-1:0]     hi_q,       hi_d;
   logic [WIDTH-1:0]     lo_q,       lo_d;
   logic                 busy_q,     busy_d;
   logic                 done_q,     done_d;
   logic                 div_zero_q, div_zero_d;

   logic                 op_valid;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_shift;

   assign op_valid = bus.start && (bus.op == OP_MULTU || bus.op == OP_DIVU);

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      is_div_d   = is_div_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;
      mul_sum    = '0;
      rem_shift  = '0;

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               a_d      = bus.src_a;
               b_d      = bus.src_b;
               count_d  = '0;
               is_div_d = (bus.op == OP_DIVU);
               if (bus.op == OP_DIVU) begin
                  acc_d   = {{WIDTH{1'b0}}, bus.src_a};
                  state_d = S_DIV;
               end else begin
                  acc_d   = '0;
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            // Upper half plus carry form a WIDTH+1 sum; the shift folds the carry back in.
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
            acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
            b_d     = b_q >> 1;
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) state_d = S_COMMIT;
         end

         S_DIV: begin
            rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
            if (rem_shift >= {1'b0, b_q}) begin
               acc_d = {rem_shift[WIDTH-1:0] - b_q, acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) state_d = S_COMMIT;
         end

         S_COMMIT: begin
            hi_d    = acc_q[2*WIDTH-1:WIDTH];
            lo_d    = acc_q[WIDTH-1:0];
            done_d  = 1'b1;
            if (is_div_q) div_zero_d = (b_q == '0);
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         is_div_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         is_div_q   <= is_div_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   // MF reads are released in COMMIT (they see the forwarded result); a new mul/div is
   // still held there so it is re-presented once the sequencer is back in IDLE.
   assign bus.stall    = busy_q && ((bus.mf_req && state_q != S_COMMIT) || op_valid);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi_out   = (state_q == S_COMMIT) ? acc_q[2*WIDTH-1:WIDTH] : hi_q;
   assign bus.lo_out   = (state_q == S_COMMIT) ? acc_q[WIDTH-1:0]       : lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: MULTU/DIVU results, latency, stall behaviour,
// divide-by-zero flag and mid-operation reset, against hand-computed values.
module tb_muldiv_hilo_ctrl;

   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

   muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op, then waits (bounded) for done; reports cycles from the accepting edge
   // and whether HI/LO held and busy stayed high for the whole iteration phase.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit hold_ok);
      logic [31:0] hi0, lo0;
      hi0     = bus.hi_out;
      lo0     = bus.lo_out;
      hold_ok = 1'b1;
      bus.start = 1'b1;
      bus.op    = o;
      bus.src_a = a;
      bus.src_b = b;
      tick();
      bus.start = 1'b0;
      bus.op    = 2'b00;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
         if (cyc <= 31 && (bus.hi_out !== hi0 || bus.lo_out !== lo0)) hold_ok = 1'b0;
         if (cyc <= 32 && bus.busy !== 1'b1) hold_ok = 1'b0;
      end
   endtask

   initial begin
      int cyc;
      bit ok;
      bit stall_ok;
      bit no_done;

      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.src_a  = '0;
      bus.src_b  = '0;
      bus.mf_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_hi", bus.hi_out, 64'h0);
         check("idle_lo", bus.lo_out, 64'h0);
         check("idle_busy", bus.busy, 64'h0);
         check("idle_stall", bus.stall, 64'h0);
      end
      check("idle_div_zero", bus.div_zero, 64'h0);

      // MULTU max x max
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, ok);
      check("mul_max_latency", cyc, 64'd33);
      check("mul_max_hold", ok, 64'h1);
      check("mul_max_hi", bus.hi_out, 64'hFFFF_FFFE);
      check("mul_max_lo", bus.lo_out, 64'h0000_0001);
      check("mul_max_busy_after", bus.busy, 64'h0);
      tick();
      check("mul_max_done_once", bus.done, 64'h0);

      // DIVU 100 / 7
      run_op(OP_DIVU, 32'd100, 32'd7, cyc, ok);
      check("div_latency", cyc, 64'd33);
      check("div_hold", ok, 64'h1);
      check("div_hi", bus.hi_out, 64'd2);
      check("div_lo", bus.lo_out, 64'd14);
      check("div_zero_clear", bus.div_zero, 64'h0);

      // DIVU by zero
      run_op(OP_DIVU, 32'h1234_5678, 32'h0, cyc, ok);
      check("div0_latency", cyc, 64'd33);
      check("div0_hi", bus.hi_out, 64'h1234_5678);
      check("div0_lo", bus.lo_out, 64'hFFFF_FFFF);
      check("div0_flag", bus.div_zero, 64'h1);

      // mf_req during MULTU 3 x 5
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.src_a = 32'd3;
      bus.src_b = 32'd5;
      tick();
      bus.start = 1'b0;
      bus.op    = 2'b00;
      stall_ok  = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         tick();
         if (c >= 5 && c <= 31 && bus.stall !== 1'b1) stall_ok = 1'b0;
         if (c == 32) begin
            check("mf_commit_stall", bus.stall, 64'h0);
            check("mf_commit_lo", bus.lo_out, 64'd15);
            check("mf_commit_hi", bus.hi_out, 64'd0);
            bus.mf_req = 1'b0;
         end
         if (c == 4) bus.mf_req = 1'b1;
         if (c == 33) begin
            check("mf_done", bus.done, 64'h1);
            check("mf_lo_reg", bus.lo_out, 64'd15);
         end
      end
      check("mf_stall_held", stall_ok, 64'h1);
      check("mul_keeps_div_zero", bus.div_zero, 64'h1);

      // Back-to-back MULTU 6 x 7 then DIVU 50 / 8 held by stall
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.src_a = 32'd6;
      bus.src_b = 32'd7;
      tick();
      bus.op    = OP_DIVU;
      bus.src_a = 32'd50;
      bus.src_b = 32'd8;
      stall_ok  = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         tick();
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (c == 32) check("b2b_commit_lo", bus.lo_out, 64'd42);
      end
      check("b2b_stall_held", stall_ok, 64'h1);
      tick();
      check("b2b_mid_done", bus.done, 64'h1);
      check("b2b_mid_lo", bus.lo_out, 64'd42);
      check("b2b_idle_stall", bus.stall, 64'h0);
      check("b2b_idle_busy", bus.busy, 64'h0);
      tick();
      bus.start = 1'b0;
      bus.op    = 2'b00;
      check("b2b_div_accepted", bus.busy, 64'h1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("b2b_div_latency", cyc, 64'd33);
      check("b2b_hi", bus.hi_out, 64'd2);
      check("b2b_lo", bus.lo_out, 64'd6);
      check("b2b_div_zero_cleared", bus.div_zero, 64'h0);

      // Reset 10 cycles into a MULTU
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.src_a = 32'h1234;
      bus.src_b = 32'h5678;
      tick();
      bus.start = 1'b0;
      bus.op    = 2'b00;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_busy", bus.busy, 64'h0);
      check("rst_hi", bus.hi_out, 64'h0);
      check("rst_lo", bus.lo_out, 64'h0);
      no_done = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
      end
      check("rst_no_done", no_done, 64'h1);
      run_op(OP_MULTU, 32'd2, 32'd3, cyc, ok);
      check("post_rst_latency", cyc, 64'd33);
      check("post_rst_hi", bus.hi_out, 64'd0);
      check("post_rst_lo", bus.lo_out, 64'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name:
muldiv_hilo_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO result registers of the pipelined MIPS-Lite CPU.
- Computes MULTU and DIVU iteratively: one bit per cycle over 32 cycles, using a shared 64-bit working register.
- Commits the result to HI/LO only when the operation finishes.
- Stalls the pipeline when MFHI/MFLO, or a new mul/div, arrives while an operation is in flight.
- Sits in EX beside the ALU; replaces the direct single-cycle HI/LO write path.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each, iteration count = WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage mul/div instruction valid.
- op  input  2  01 = MULTU, 10 = DIVU; 00 and 11 mean no operation.
- src_a  input  WIDTH  multiplicand / dividend (rs).
- src_b  input  WIDTH  multiplier / divisor (rt).
- mf_req  input  1  MFHI or MFLO in EX needs HI/LO this cycle.
- busy  output  1  operation in flight.
- stall  output  1  hold the IF/ID/EX pipeline stages.
- done  output  1  one-cycle pulse when HI/LO are committed.
- div_zero  output  1  sticky flag: last DIVU had divisor 0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state = IDLE; busy, stall, done, div_zero = 0; hi_out = lo_out = 0.
  - Counter, working register and operand latches cleared.
  - Any in-flight operation is aborted with no commit.
- State machine: IDLE, MUL, DIV, COMMIT.
  - IDLE: if start and op = 01, latch src_a/src_b, clear the 64-bit accumulator, count = 0, go to MUL.
  - IDLE: if start and op = 10, latch operands, remainder = 0, count = 0, go to DIV.
  - IDLE: start with op = 00 or 11 is ignored.
  - MUL: one shift-add step per cycle. If the multiplier LSB = 1, add the multiplicand into the upper half (carry kept in a 65th bit). Then shift the {carry, acc} register right by 1. count++. After step WIDTH-1, go to COMMIT.
  - DIV: restoring division. Shift {rem, quot} left by 1, trial-subtract the divisor from rem. If no borrow, keep the difference and set quotient bit = 1; else restore and set bit = 0. count++. After step WIDTH-1, go to COMMIT.
  - COMMIT (1 cycle): hi_out/lo_out load the result, done = 1, return to IDLE.
    - MULTU: hi = product[63:32], lo = product[31:0].
    - DIVU: hi = remainder, lo = quotient.
- Latency: start sampled at edge N; hi/lo and done become visible after edge N+33. busy is high from edge N+1 through the COMMIT cycle inclusive.
- stall = busy & (mf_req | (start & (op = 01 | op = 10))). Combinational.
  - Stall deasserts in the COMMIT cycle so an MFHI in that cycle reads the committed value.
  - To allow this, hi_out/lo_out expose the commit value combinationally during COMMIT (forwarding); registers update at the edge.
- Unless stalled, mf_req never changes state.
- hi_out/lo_out hold their previous values for the whole of MUL/DIV; partial results are never visible.
- Divide by zero:
  - No special path; runs the full 32 cycles, giving quotient = 0xFFFFFFFF and remainder = dividend.
  - div_zero is set at COMMIT if the divisor was 0.
  - div_zero is cleared at the next DIVU commit with a nonzero divisor, or by reset.
- start while busy: not accepted. The pipeline holds the instruction via stall, and it is re-presented and accepted in the cycle after COMMIT (when state is IDLE).
- The simultaneous start and mf_req in IDLE case cannot occur (a single EX stage); if it does, start wins and stall = 0 that cycle.
- Arithmetic is unsigned throughout; no overflow is possible (64-bit product).

Test Plan:
- Reset then idle: hi_out = lo_out = 0, busy = 0, stall = 0 for 5 cycles with start = 0.
- MULTU src_a = 0xFFFFFFFF, src_b = 0xFFFFFFFF:
  - Exactly 33 cycles later done pulses once.
  - hi = 0xFFFFFFFE, lo = 0x00000001.
  - hi/lo unchanged (0) during busy.
- DIVU 100 / 7:
  - hi = 2, lo = 14, div_zero = 0.
  - Then DIVU 0x12345678 / 0: hi = 0x12345678, lo = 0xFFFFFFFF, div_zero = 1.
- mf_req asserted 5 cycles after a MULTU 3 x 5 start:
  - stall = 1 until the COMMIT cycle.
  - In COMMIT, stall = 0 and lo_out reads 15.
- Back-to-back: MULTU 6 x 7 followed immediately by DIVU 50 / 8 held by stall:
  - DIVU is accepted the cycle after COMMIT.
  - Final hi = 2, lo = 6; the intermediate commit was lo = 42.
- reset pulsed 10 cycles into a MULTU:
  - busy drops next cycle and hi/lo = 0.
  - done never pulses.
  - A subsequent MULTU 2 x 3 gives lo = 6.
